// File: rtl/hub75_scan_controller.sv
// HUB-75 panel sequencer: row scan, bit-plane modulation, pixel shift, latch and OE.
// Define HUB75_BLANK_EN to insert BLANK_TICKS oe-high cycles before each row change.
module hub75_scan_controller #(
  parameter int COLS        = 64,
  parameter int ROW_BITS    = 5,
  parameter int PLANES      = 8,
  parameter int BASE_TICKS  = 4,
  parameter int BLANK_TICKS = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  output logic                      pix_req,
  output logic [$clog2(COLS)-1:0]   pix_x,
  output logic [ROW_BITS-1:0]       pix_row,
  output logic [$clog2(PLANES)-1:0] pix_plane,
  input  logic                      pix_ack,
  input  logic [5:0]                pix_data,
  output logic                      r1,
  output logic                      g1,
  output logic                      b1,
  output logic                      r2,
  output logic                      g2,
  output logic                      b2,
  output logic [ROW_BITS-1:0]       abcd,
  output logic                      clk,
  output logic                      lat,
  output logic                      oe,
  output logic                      frame_done,
  output logic                      busy,
  output logic [2:0]                fsm_state
);

  localparam int X_W      = $clog2(COLS);
  localparam int P_W      = $clog2(PLANES);
  localparam int SHOW_MAX = BASE_TICKS << (PLANES - 1);
  localparam int CNT_MAX  = (SHOW_MAX > BLANK_TICKS) ? SHOW_MAX : BLANK_TICKS;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] CLKHI = 3'd2;
  localparam logic [2:0] LATCH = 3'd3;
  localparam logic [2:0] SHOW  = 3'd4;
`ifdef HUB75_BLANK_EN
  localparam logic [2:0] BLANK = 3'd5;
`endif

  logic [2:0]          state;
  logic [X_W-1:0]      x;
  logic [ROW_BITS-1:0] row;
  logic [P_W-1:0]      plane;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    show_len_m1;
  logic                last_plane;
  logic                last_row;

  // Pixel port: pix_req rises with {pix_x,pix_row,pix_plane} stable and stays high
  // until a cycle with pix_ack=1; pix_data is taken in that cycle. Ack without req is ignored.
  assign pix_x       = x;
  assign pix_row     = row;
  assign pix_plane   = plane;
  assign busy        = (state != IDLE);
  assign fsm_state   = state;
  assign last_plane  = (plane == P_W'(PLANES - 1));
  assign last_row    = &row;
  assign show_len_m1 = (CNT_W'(BASE_TICKS) << plane) - CNT_W'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pix_req    <= 1'b0;
      x          <= '0;
      row        <= '0;
      plane      <= '0;
      cnt        <= '0;
      {r1, g1, b1, r2, g2, b2} <= 6'b0;
      abcd       <= '0;
      clk        <= 1'b0;
      lat        <= 1'b0;
      oe         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          oe  <= 1'b1;
          clk <= 1'b0;
          if (enable) begin
            state   <= FETCH;
            pix_req <= 1'b1;
          end
        end
        FETCH: begin
          if (pix_req && pix_ack) begin
            {r1, g1, b1, r2, g2, b2} <= pix_data;
            pix_req <= 1'b0;
            clk     <= 1'b1;
            state   <= CLKHI;
          end
        end
        CLKHI: begin
          clk <= 1'b0;
          if (x == X_W'(COLS - 1)) begin
            x     <= '0;
            lat   <= 1'b1;
            abcd  <= row;
            state <= LATCH;
          end else begin
            x       <= x + X_W'(1);
            pix_req <= 1'b1;
            state   <= FETCH;
          end
        end
        LATCH: begin
          lat   <= 1'b0;
          oe    <= 1'b0;
          cnt   <= show_len_m1;
          state <= SHOW;
        end
        SHOW: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Last display cycle: pick the next (row, plane) and decide whether to keep going.
            oe         <= 1'b1;
            plane      <= last_plane ? '0 : plane + P_W'(1);
            row        <= last_plane ? row + ROW_BITS'(1) : row;
            frame_done <= last_plane && last_row;
            if (!enable) begin
              state <= IDLE;
`ifdef HUB75_BLANK_EN
            end else if (last_plane) begin
              cnt   <= CNT_W'(BLANK_TICKS - 1);
              state <= BLANK;
`endif
            end else begin
              pix_req <= 1'b1;
              state   <= FETCH;
            end
          end
        end
`ifdef HUB75_BLANK_EN
        BLANK: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            pix_req <= 1'b1;
            state   <= FETCH;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_controller.sv
// Self-checking bench for hub75_scan_controller: random ack delays and enable toggling
// against an event-level model of the scan order, shift, latch and display timing.
module tb_hub75_scan_controller;

  localparam int COLS        = 4;
  localparam int ROW_BITS    = 2;
  localparam int PLANES      = 4;
  localparam int BASE_TICKS  = 2;
  localparam int BLANK_TICKS = 2;
  localparam int ROWS        = 1 << ROW_BITS;
  localparam int XW          = $clog2(COLS);
  localparam int PW          = $clog2(PLANES);
  localparam int AW          = XW + ROW_BITS + PW;
`ifdef HUB75_BLANK_EN
  localparam int GAP           = BLANK_TICKS;
  localparam int FRAME_LEN_LIT = 272;
`else
  localparam int GAP           = 0;
  localparam int FRAME_LEN_LIT = 264;
`endif
  // 2*(1+2+4+8) oe-low cycles per row
  localparam int ROW_OE_LOW_LIT = 30;

  logic                clock = 1'b0;
  logic                reset;
  logic                enable;
  logic                pix_req;
  logic [XW-1:0]       pix_x;
  logic [ROW_BITS-1:0] pix_row;
  logic [PW-1:0]       pix_plane;
  logic                pix_ack;
  logic [5:0]          pix_data;
  logic                r1, g1, b1, r2, g2, b2;
  logic [ROW_BITS-1:0] abcd;
  logic                clk, lat, oe, frame_done, busy;
  logic [2:0]          fsm_state;

  hub75_scan_controller #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .PLANES(PLANES),
    .BASE_TICKS(BASE_TICKS), .BLANK_TICKS(BLANK_TICKS)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .pix_req(pix_req), .pix_x(pix_x), .pix_row(pix_row), .pix_plane(pix_plane),
    .pix_ack(pix_ack), .pix_data(pix_data),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .abcd(abcd), .clk(clk), .lat(lat), .oe(oe),
    .frame_done(frame_done), .busy(busy), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard queues: acked data and the address it was fetched for
  logic [5:0]    exp_q[$];
  logic [AW-1:0] addr_q[$];

  bit zero_wait = 1'b1;
  bit spur_en   = 1'b0;
  bit measure   = 1'b0;
  int fd_count  = 0;

  // driver: frame-store responder with random latency and stray acks
  initial begin
    int delay;
    delay    = -1;
    pix_ack  = 1'b0;
    pix_data = 6'd0;
    forever begin
      @(negedge clock);
      pix_ack = 1'b0;
      if (reset !== 1'b1) begin
        delay = -1;
      end else if (pix_req === 1'b1) begin
        if (delay < 0) delay = zero_wait ? 0 : int'($urandom_range(0, 5));
        if (delay == 0) begin
          pix_ack  = 1'b1;
          pix_data = 6'($urandom);
          exp_q.push_back(pix_data);
          addr_q.push_back({pix_x, pix_row, pix_plane});
          delay = -1;
        end else begin
          delay--;
        end
      end else if (spur_en && $urandom_range(0, 5) == 0) begin
        pix_ack  = 1'b1;
        pix_data = 6'($urandom);
      end
    end
  end

  // model + compare process, sampled 1 time unit after each rising edge
  initial begin
    int m_row, m_plane, clk_cnt, show_rem, gap, oe_row_sum, since_fd;
    bit post, rowchg, fd_next, prev_clk, meas_armed;
    logic [5:0]    d;
    logic [AW-1:0] a, ea;
    m_row = 0; m_plane = 0; clk_cnt = 0; show_rem = 0; gap = -1; oe_row_sum = 0;
    since_fd = 0; post = 0; rowchg = 0; fd_next = 0; prev_clk = 0; meas_armed = 0;
    forever begin
      @(posedge clock);
      #1;
      if (reset !== 1'b1) begin
        m_row = 0; m_plane = 0; clk_cnt = 0; show_rem = 0; gap = -1; oe_row_sum = 0;
        since_fd = 0; post = 0; rowchg = 0; fd_next = 0; prev_clk = 0; meas_armed = 0;
        exp_q.delete();
        addr_q.delete();
      end else begin
        check_eq("frame_done", frame_done, fd_next);
        fd_next = 0;
        since_fd++;
        if (frame_done === 1'b1) begin
          if (measure && meas_armed) check_eq("frame_len", since_fd, FRAME_LEN_LIT);
          meas_armed = measure;
          since_fd   = 0;
          fd_count++;
        end
        if (post) begin
          post = 0;
          if (enable === 1'b1) begin
            gap = rowchg ? GAP : 0;
          end else begin
            check_eq("idle_busy", busy, 0);
            check_eq("idle_req", pix_req, 0);
            gap = -1;
          end
        end
        if (gap == 0) begin
          check_eq("next_req", pix_req, 1);
          check_eq("next_x", pix_x, 0);
          gap = -1;
        end else if (gap > 0) begin
          check_eq("blank_req", pix_req, 0);
          gap--;
        end
        check_eq("oe", oe, (show_rem > 0) ? 0 : 1);
        if (show_rem > 0) begin
          oe_row_sum++;
          show_rem--;
          if (show_rem == 0) begin
            rowchg  = (m_plane == PLANES - 1);
            fd_next = rowchg && (m_row == ROWS - 1);
            if (rowchg) begin
              check_eq("row_oe_low", oe_row_sum, ROW_OE_LOW_LIT);
              oe_row_sum = 0;
              m_plane    = 0;
              m_row      = (m_row + 1) % ROWS;
            end else begin
              m_plane++;
            end
            post = 1;
          end
        end
        if (clk === 1'b1) begin
          check_eq("clk_while_req", pix_req, 0);
          check_eq("clk_single", prev_clk, 0);
          if (exp_q.size() == 0) begin
            check_eq("clk_without_ack", 1, 0);
          end else begin
            d  = exp_q.pop_front();
            a  = addr_q.pop_front();
            ea = {XW'(clk_cnt), ROW_BITS'(m_row), PW'(m_plane)};
            check_eq("rgb", {r1, g1, b1, r2, g2, b2}, d);
            check_eq("fetch_addr", a, ea);
          end
          clk_cnt++;
        end
        prev_clk = (clk === 1'b1);
        if (lat === 1'b1) begin
          check_eq("lat_cols", clk_cnt, COLS);
          check_eq("abcd", abcd, m_row);
          check_eq("lat_clk", clk, 0);
          clk_cnt  = 0;
          show_rem = BASE_TICKS << m_plane;
        end
      end
    end
  end

  task automatic wait_frames(input int k, input int lim);
    int start, n;
    start = fd_count;
    n = 0;
    while (fd_count < start + k && n < lim) begin
      @(negedge clock);
      n++;
    end
    check_eq("frame_wait_in_time", (n < lim), 1);
  endtask

  task automatic wait_req(input int lim, output bit ok);
    int n;
    n = 0;
    while (pix_req !== 1'b1 && n < lim) begin
      @(negedge clock);
      n++;
    end
    ok = (n < lim);
  endtask

  // main sequence + final report
  initial begin
    bit ok;
    int n;
    reset  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_oe", oe, 1);
    check_eq("rst_lat", lat, 0);
    check_eq("rst_clk", clk, 0);
    check_eq("rst_req", pix_req, 0);
    check_eq("rst_abcd", abcd, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rgb", {r1, g1, b1, r2, g2, b2}, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("idle_no_enable", busy, 0);

    enable = 1'b1;
    wait_req(20, ok);
    check_eq("first_req_in_time", ok, 1);
    check_eq("first_x", pix_x, 0);
    check_eq("first_row", pix_row, 0);
    check_eq("first_plane", pix_plane, 0);
    measure = 1'b1;
    wait_frames(3, 1500);

    measure   = 1'b0;
    zero_wait = 1'b0;
    spur_en   = 1'b1;
    wait_frames(1, 3000);

    // drop enable while fetching row 3 plane 2
    n = 0;
    while (!(pix_req === 1'b1 && pix_row == 3 && pix_plane == 2) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check_eq("find_r3p2", (n < 3000), 1);
    enable = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    check_eq("idle_after_drop", (n < 500), 1);
    check_eq("idle_oe", oe, 1);
    repeat ($urandom_range(3, 10)) @(negedge clock);
    check_eq("stay_idle", busy, 0);
    enable = 1'b1;
    wait_req(20, ok);
    check_eq("resume_in_time", ok, 1);
    check_eq("resume_row", pix_row, 3);
    check_eq("resume_plane", pix_plane, 3);
    check_eq("resume_x", pix_x, 0);

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(5, 60)) @(negedge clock);
      enable = ~enable;
    end
    enable = 1'b1;
    wait_frames(1, 3000);

    // asynchronous reset in the middle of a display period
    n = 0;
    while (!(oe === 1'b0 && abcd != 0) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check_eq("find_show", (n < 3000), 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_oe", oe, 1);
    check_eq("async_lat", lat, 0);
    check_eq("async_clk", clk, 0);
    check_eq("async_req", pix_req, 0);
    check_eq("async_abcd", abcd, 0);
    enable = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    enable = 1'b1;
    wait_req(20, ok);
    check_eq("post_rst_in_time", ok, 1);
    check_eq("post_rst_x", pix_x, 0);
    check_eq("post_rst_row", pix_row, 0);
    check_eq("post_rst_plane", pix_plane, 0);
    wait_frames(1, 3000);
    repeat (5) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
